// File: rtl/spectrum_line_ctrl.sv
// Spectrum bar controller: captures one FFT frame of scaled bar lengths into a
// ping-pong buffer and serves them to the LCD renderer one line per request.
module spectrum_line_ctrl #(
  parameter int                 DATA_W    = 16,
  parameter int                 LINE_NUM  = 128,
  parameter int                 MAG_SHIFT = 4,
  parameter logic [DATA_W-1:0]  MAX_LEN   = 16'd200
) (
  input  logic                        lcd_clk,
  input  logic                        sys_rst_n,
  input  logic                        fft_valid,
  input  logic                        fft_sop,
  input  logic [DATA_W-1:0]           fft_mag,
  output logic                        fft_ready,
  input  logic                        data_req,
  input  logic                        wr_over,
  output logic [$clog2(LINE_NUM)-1:0] line_cnt,
  output logic [DATA_W-1:0]           line_length,
  output logic                        frame_swap
);

  localparam int            AW   = $clog2(LINE_NUM);
  localparam logic [AW-1:0] LAST = AW'(LINE_NUM - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} wstate_t;

  function automatic logic [DATA_W-1:0] sat_len(input logic [DATA_W-1:0] mag);
    logic [DATA_W-1:0] scaled;
    scaled = mag >> MAG_SHIFT;
    return (scaled > MAX_LEN) ? MAX_LEN : scaled;
  endfunction

  wstate_t           wstate;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     wr_a;
  logic              wr_en;
  logic              wbank;
  logic              wbank_full;
  logic              rbank_valid;
  logic              swap;
  logic [AW-1:0]     rd_ptr;

  logic              vld_p0;
  logic [AW-1:0]     cnt_p0;
  logic              vld_p1;
  logic [AW-1:0]     cnt_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              rvalid_p1;

  // Both banks in one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [0:2*LINE_NUM-1];

  always_comb begin
    fft_ready = (wstate != W_DONE);
    wr_en     = fft_valid && fft_ready && (fft_sop || (wstate == W_FILL));
    wr_a      = fft_sop ? '0 : wr_addr;
    swap      = wr_over && wbank_full;
  end

  always_ff @(posedge lcd_clk) begin
    if (wr_en) mem[{wbank, wr_a}] <= sat_len(fft_mag);
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wstate      <= W_IDLE;
      wr_addr     <= '0;
      wbank       <= 1'b0;
      wbank_full  <= 1'b0;
      rbank_valid <= 1'b0;
      frame_swap  <= 1'b0;
      rd_ptr      <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      line_cnt    <= '0;
      line_length <= '0;
    end else begin
      frame_swap <= swap;
      if (swap) begin
        wbank       <= ~wbank;
        wbank_full  <= 1'b0;
        rbank_valid <= 1'b1;
      end

      case (wstate)
        W_IDLE, W_FILL: begin
          if (wr_en) begin
            wr_addr <= wr_a + 1'b1;
            if (wr_a == LAST) begin
              wbank_full <= 1'b1;
              wstate     <= W_DONE;
            end else begin
              wstate <= W_FILL;
            end
          end
        end
        W_DONE:  if (swap) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase

      // p0: accept request; a frame boundary drops a coincident request
      vld_p0 <= data_req && !wr_over;
      if (wr_over)
        rd_ptr <= '0;
      else if (data_req)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

      // p1 -> output
      vld_p1 <= vld_p0;
      if (vld_p1) begin
        line_cnt    <= cnt_p1;
        line_length <= rvalid_p1 ? rdata_p1 : '0;
      end
    end
  end

  // p1: synchronous bank read
  always_ff @(posedge lcd_clk) begin
    cnt_p0    <= rd_ptr;
    cnt_p1    <= cnt_p0;
    rdata_p1  <= mem[{~wbank, cnt_p0}];
    rvalid_p1 <= rbank_valid;
  end

endmodule

// File: tb/tb_spectrum_line_ctrl.sv
// Directed bench for spectrum_line_ctrl: fill, scale, swap and read-out sequences.
module tb_spectrum_line_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fft_valid, fft_sop;
  logic [15:0] fft_mag;
  logic        fft_ready;
  logic        data_req, wr_over;
  logic [6:0]  line_cnt;
  logic [15:0] line_length;
  logic        frame_swap;

  int n_cmp = 0;
  int n_err = 0;
  int swap_cnt = 0;
  int swap_ref;
  int e_len;

  spectrum_line_ctrl dut (
    .lcd_clk    (clk),
    .sys_rst_n  (rst_n),
    .fft_valid  (fft_valid),
    .fft_sop    (fft_sop),
    .fft_mag    (fft_mag),
    .fft_ready  (fft_ready),
    .data_req   (data_req),
    .wr_over    (wr_over),
    .line_cnt   (line_cnt),
    .line_length(line_length),
    .frame_swap (frame_swap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_swap) swap_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sop, input logic [15:0] mag);
    fft_valid = 1'b1;
    fft_sop   = sop;
    fft_mag   = mag;
    tick();
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
  endtask

  task automatic pulse_wr_over;
    wr_over = 1'b1;
    tick();
    wr_over = 1'b0;
  endtask

  task automatic req_check(input string tag, input int e_cnt, input int e_l);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    tick();
    tick();
    chk({tag, ".cnt"}, line_cnt, e_cnt);
    chk({tag, ".len"}, line_length, e_l);
  endtask

  initial begin
    rst_n = 1'b0; fft_valid = 1'b0; fft_sop = 1'b0; fft_mag = '0;
    data_req = 1'b0; wr_over = 1'b0;
    #3;
    chk("rst.ready", fft_ready, 1);
    chk("rst.cnt",   line_cnt, 0);
    chk("rst.len",   line_length, 0);
    chk("rst.swap",  frame_swap, 0);
    #14 rst_n = 1'b1;
    tick();

    // Test 1: back-to-back requests with no FFT data
    data_req = 1'b1;
    tick(); tick();
    tick(); chk("t1.cnt0", line_cnt, 0); chk("t1.len0", line_length, 0);
    tick(); chk("t1.cnt1", line_cnt, 1);
    tick(); chk("t1.cnt2", line_cnt, 2);
    data_req = 1'b0;
    tick(); chk("t1.cnt3", line_cnt, 3);
    tick(); chk("t1.cnt4", line_cnt, 4); chk("t1.len4", line_length, 0);
    tick(); chk("t1.hold", line_cnt, 4);
    chk("t1.ready", fft_ready, 1);
    chk("t1.noswap", swap_cnt, 0);

    // Test 2: scaling and saturation
    for (int k = 0; k < 128; k++) begin
      chk($sformatf("t2.rdy%0d", k), fft_ready, 1);
      send(k == 0, 16'(k * 64));
    end
    chk("t2.ready_low", fft_ready, 0);
    pulse_wr_over();
    chk("t2.swap_hi", frame_swap, 1);
    chk("t2.ready_back", fft_ready, 1);
    tick();
    chk("t2.swap_lo", frame_swap, 0);
    for (int k = 0; k < 128; k++) begin
      e_len = (4 * k > 200) ? 200 : 4 * k;
      req_check($sformatf("t2.l%0d", k), k, e_len);
    end
    req_check("t2.wrap", 0, 0);
    chk("t2.swaps", swap_cnt, 1);

    // Test 3: second frame blocked until the renderer frees a bank
    for (int k = 0; k < 128; k++) send(k == 0, 16'((k + 1) * 16));
    chk("t3.ready_low", fft_ready, 0);
    for (int k = 0; k < 128; k++) send(k == 0, 16'd1600);
    chk("t3.still_low", fft_ready, 0);
    pulse_wr_over();
    chk("t3.swap_hi", frame_swap, 1);
    chk("t3.ready_back", fft_ready, 1);
    req_check("t3.b0", 0, 1);
    req_check("t3.b1", 1, 2);
    req_check("t3.b2", 2, 3);
    for (int k = 0; k < 128; k++) send(k == 0, 16'((200 - k) * 16));
    chk("t3.c_full", fft_ready, 0);
    pulse_wr_over();
    req_check("t3.c0", 0, 200);
    req_check("t3.c1", 1, 199);
    req_check("t3.c2", 2, 198);
    chk("t3.swaps", swap_cnt, 3);

    // Test 4: restart mid-fill, then a repeated wr_over
    for (int k = 0; k < 50; k++) send(k == 0, 16'h7ff0);
    for (int j = 0; j < 78; j++) send(j == 0, 16'((3 * j + 5) * 16));
    chk("t4.ready_mid", fft_ready, 1);
    for (int j = 78; j < 128; j++) send(1'b0, 16'((3 * j + 5) * 16));
    chk("t4.ready_low", fft_ready, 0);
    pulse_wr_over();
    chk("t4.swap_hi", frame_swap, 1);
    req_check("t4.l0", 0, 5);
    req_check("t4.l1", 1, 8);
    req_check("t4.l2", 2, 11);
    swap_ref = swap_cnt;
    pulse_wr_over();
    chk("t4.noswap_pulse", frame_swap, 0);
    req_check("t4.redisp0", 0, 5);
    chk("t4.noswap_cnt", swap_cnt, swap_ref);

    // Test 5: coincident wr_over and data_req
    for (int k = 0; k < 128; k++) send(k == 0, 16'((k + 10) * 16));
    wr_over = 1'b1; data_req = 1'b1;
    tick();
    wr_over = 1'b0; data_req = 1'b0;
    chk("t5.swap_hi", frame_swap, 1);
    tick(); tick(); tick();
    chk("t5.drop.cnt", line_cnt, 0);
    chk("t5.drop.len", line_length, 5);
    chk("t5.swaps", swap_cnt, swap_ref + 1);
    req_check("t5.l0", 0, 10);
    req_check("t5.l1", 1, 11);

    // Test 6: asynchronous reset mid-fill with the read pointer at 60
    data_req = 1'b1;
    for (int k = 0; k < 58; k++) tick();
    data_req = 1'b0;
    tick(); tick();
    chk("t6.pre.cnt", line_cnt, 59);
    chk("t6.pre.len", line_length, 69);
    for (int k = 0; k < 20; k++) send(k == 0, 16'd320);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst.ready", fft_ready, 1);
    chk("t6.rst.cnt",   line_cnt, 0);
    chk("t6.rst.len",   line_length, 0);
    chk("t6.rst.swap",  frame_swap, 0);
    #2 rst_n = 1'b1;
    tick();
    req_check("t6.after", 0, 0);
    swap_ref = swap_cnt;
    pulse_wr_over();
    chk("t6.noswap", frame_swap, 0);
    req_check("t6.after2", 0, 0);
    chk("t6.swaps", swap_cnt, swap_ref);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
